altavoz: RTL and testbench

ALTAVOZ -- requirements
Module: altavoz

---
 rtl/altavoz.sv | 166 ++++++++++++++++
 tb/tb_altavoz.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/altavoz.sv
`default_nettype none
// ============================================================================
//  Module   : altavoz
//  Purpose  : Left-justified mono PCM serializer. A parallel sample is latched
//             at every frame start and shifted out MSB first, once in the left
//             half (rlclk=0) and once in the right half (rlclk=1) of a frame of
//             2*WIDTH bit-clock slots. The bit clock is derived from clk by a
//             programmable divider.
//  Ports    : clk      - system clock, rising edge
//             reset    - asynchronous active-low reset
//             enable   - 1 = transmit continuously, 0 = idle / abort frame
//             sregt    - parallel two's complement sample, latched at frame start
//             bclk     - serial bit clock (registered)
//             rlclk    - word select, 0 = left half, 1 = right half (registered)
//             dataout  - serial data, MSB first (registered)
//             done     - one-clk pulse when a full frame completes (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module altavoz #(
    parameter int DIV   = 2,    // clk cycles per bclk half period, 1..255
    parameter int WIDTH = 16    // PCM sample width in bits
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sregt,
    output logic             bclk,
    output logic             rlclk,
    output logic             dataout,
    output logic             done
);

    localparam int                 SLOT_W     = $clog2(2 * WIDTH);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(2 * WIDTH - 1);
    localparam logic [SLOT_W-1:0]  SLOT_RIGHT = SLOT_W'(WIDTH);
    localparam logic [7:0]         DIV_LAST   = 8'(DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q,  state_d;
    logic [7:0]        div_q,    div_d;
    logic [SLOT_W-1:0] slot_q,   slot_d;
    logic              bclk_q,   bclk_d;
    logic              rlclk_q,  rlclk_d;
    logic              dout_q,   dout_d;
    logic              done_q,   done_d;
    logic [WIDTH-1:0]  sample_q, sample_d;
    logic [WIDTH-1:0]  shift_q,  shift_d;

    logic [SLOT_W-1:0] slot_inc;
    logic              div_wrap;

    assign slot_inc = slot_q + SLOT_W'(1);
    assign div_wrap = (div_q == DIV_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            slot_q   <= '0;
            bclk_q   <= 1'b0;
            rlclk_q  <= 1'b0;
            dout_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            slot_q   <= slot_d;
            bclk_q   <= bclk_d;
            rlclk_q  <= rlclk_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        slot_d   = slot_q;
        bclk_d   = bclk_q;
        rlclk_d  = rlclk_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        sample_d = sample_q;
        shift_d  = shift_q;

        if (!enable) begin
            // Idle or abort: counters and outputs clear, the sample is kept.
            state_d = ST_IDLE;
            div_d   = '0;
            slot_d  = '0;
            bclk_d  = 1'b0;
            rlclk_d = 1'b0;
            dout_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Fresh frame: the first bit is presented immediately so
                    // that it is stable before the first rising bclk.
                    state_d  = ST_RUN;
                    sample_d = sregt;
                    shift_d  = sregt;
                    div_d    = '0;
                    slot_d   = '0;
                    bclk_d   = 1'b0;
                    rlclk_d  = 1'b0;
                    dout_d   = sregt[WIDTH-1];
                end
                ST_RUN: begin
                    if (div_wrap) begin
                        div_d  = '0;
                        bclk_d = ~bclk_q;
                        // Slot, data and word select only move on the edge
                        // that drives bclk low, keeping them stable around
                        // every rising bclk.
                        if (bclk_q) begin
                            if (slot_q == SLOT_LAST) begin
                                slot_d   = '0;
                                sample_d = sregt;
                                shift_d  = sregt;
                                rlclk_d  = 1'b0;
                                dout_d   = sregt[WIDTH-1];
                                done_d   = 1'b1;
                            end else begin
                                slot_d = slot_inc;
                                // Right half replays the same latched sample.
                                if (slot_inc == SLOT_RIGHT) begin
                                    shift_d = sample_q;
                                end else begin
                                    shift_d = shift_q << 1;
                                end
                                rlclk_d = (slot_inc >= SLOT_RIGHT);
                                dout_d  = shift_d[WIDTH-1];
                            end
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bclk    = bclk_q;
    assign rlclk   = rlclk_q;
    assign dataout = dout_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_altavoz.sv
`default_nettype none
// ============================================================================
//  Module   : tb_altavoz
//  Purpose  : Self-checking bench for altavoz. Two instances (DIV=2, DIV=1)
//             share stimulus; outputs are compared every clk against a
//             frame-timing reference model plus directed pattern checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_altavoz;

    localparam int W  = 16;
    localparam int FA = 2 * W * 2 * 2;   // frame length, DIV=2
    localparam int FB = 2 * W * 2 * 1;   // frame length, DIV=1

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  sregt;
    logic          bclk_a, rlclk_a, dout_a, done_a;
    logic          bclk_b, rlclk_b, dout_b, done_b;

    altavoz #(.DIV(2), .WIDTH(W)) u_dut_a (
        .clk(clk), .reset(rst_n), .enable(en), .sregt(sregt),
        .bclk(bclk_a), .rlclk(rlclk_a), .dataout(dout_a), .done(done_a)
    );

    altavoz #(.DIV(1), .WIDTH(W)) u_dut_b (
        .clk(clk), .reset(rst_n), .enable(en), .sregt(sregt),
        .bclk(bclk_b), .rlclk(rlclk_b), .dataout(dout_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int           vectors     = 0;
    int           miscompares = 0;

    // Reference model state: running flag, clk edges since start, and the
    // sample each instance latched at its current frame start.
    bit           run = 1'b0;
    int           t   = 0;
    logic [W-1:0] samp_a = '0;
    logic [W-1:0] samp_b = '0;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b (t=%0d run=%0b)", tag, obs, exp, t, run);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {bclk, rlclk, dataout, done} from frame position arithmetic.
    function automatic logic [3:0] model(input int div, input logic [W-1:0] s);
        int f, u, slot;
        if (!run) return 4'b0000;
        f    = 2 * W * 2 * div;
        u    = t % f;
        slot = u / (2 * div);
        return { ((u / div) % 2) == 1, slot >= W, s[W-1-(slot % W)], (t > 0) && (u == 0) };
    endfunction

    task automatic compare_all();
        logic [3:0] ea, eb;
        ea = model(2, samp_a);
        eb = model(1, samp_b);
        check("a.bclk",    bclk_a,  ea[3]);
        check("a.rlclk",   rlclk_a, ea[2]);
        check("a.dataout", dout_a,  ea[1]);
        check("a.done",    done_a,  ea[0]);
        check("b.bclk",    bclk_b,  eb[3]);
        check("b.rlclk",   rlclk_b, eb[2]);
        check("b.dataout", dout_b,  eb[1]);
        check("b.done",    done_b,  eb[0]);
    endtask

    // One clk edge: advance model with the inputs seen at that edge, compare.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n || !en) begin
            run = 1'b0;
        end else if (!run) begin
            run    = 1'b1;
            t      = 0;
            samp_a = sregt;
            samp_b = sregt;
        end else begin
            t++;
            if (t % FA == 0) samp_a = sregt;
            if (t % FB == 0) samp_b = sregt;
        end
        compare_all();
    endtask

    // Reset dropped between edges: outputs must clear before the next edge.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        run = 1'b0;
        check("async.bclk",    bclk_a,  1'b0);
        check("async.rlclk",   rlclk_a, 1'b0);
        check("async.dataout", dout_a | dout_b, 1'b0);
        check("async.done",    done_a | done_b, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] seq1, seq2;
        int          dcnt_a, dcnt_b, off_cnt, r;

        seq1 = '0; seq2 = '0; dcnt_a = 0; dcnt_b = 0; off_cnt = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        sregt = 16'hB1B1;

        // Reset held for three edges with enable already high.
        #1;
        compare_all();
        for (int i = 0; i < 3; i++) step();

        // Release: start, two frames of DIV=2, sample change at clk 40.
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 40) sregt = 16'h8000;
            step();
            if (i < FA && (i % 4) == 2)                seq1[31 - i / 4]          = dout_a;
            if (i >= FA && i < 2 * FA && (i % 4) == 2) seq2[31 - (i - FA) / 4]   = dout_a;
            if (done_a) dcnt_a++;
            if (done_b) dcnt_b++;
        end
        check32("frame1.bits", seq1, {16'hB1B1, 16'hB1B1});
        check32("frame2.bits", seq2, {16'h8000, 16'h8000});
        check32("done.count.div2", 32'(dcnt_a), 32'd2);
        check32("done.count.div1", 32'(dcnt_b), 32'd4);

        // Abort at clk 50 of a frame, then restart with the current sample.
        for (int i = 0; i < 2 * FA && (t % FA) != 50; i++) step();
        en = 1'b0;
        step();
        sregt = 16'h5A3C;
        en    = 1'b1;
        step();
        check("restart.dataout", dout_a, 1'b0);
        for (int i = 0; i < 140; i++) step();

        // Asynchronous reset at clk 70 of a fresh frame.
        en = 1'b0;
        step();
        en = 1'b1;
        for (int i = 0; i < 71; i++) step();
        async_reset_pulse();
        for (int i = 0; i < 140; i++) step();

        // Randomized traffic: sample changes, short aborts, reset pulses.
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 999));
            if (off_cnt > 0) begin
                off_cnt--;
                if (off_cnt == 0) en = 1'b1;
            end else if (r < 30) begin
                sregt = 16'($urandom);
            end else if (r < 36) begin
                en      = 1'b0;
                off_cnt = int'($urandom_range(1, 6));
            end else if (r < 39) begin
                async_reset_pulse();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
